// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_queue
// Description : Byte FIFO feeding a UART transmitter. Releases one byte at a
//               time on d_in with a fixed-width tx_send request, then tracks
//               the transmitter's (synchronised) sending flag until the frame
//               completes. Optional drop counter: UART_TXQ_DROP_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue #(
    parameter int DEPTH_LOG2    = 4,
    parameter int SEND_HOLD     = 4,
    parameter int START_TIMEOUT = 1024
) (
    input  logic                  clock,
    input  logic                  clrn,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic [7:0]            d_in,
    output logic                  tx_send,
    input  logic                  sending,
    output logic                  busy,
    output logic                  overflow,
    output logic                  timeout_err
`ifdef UART_TXQ_DROP_COUNT_EN
    ,
    output logic [7:0]            drop_count
`endif
);

    localparam int c_DEPTH  = 1 << DEPTH_LOG2;
    localparam int c_HOLD_W = $clog2(SEND_HOLD + 1);
    localparam int c_TO_W   = $clog2(START_TIMEOUT);

    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   c_LVL_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   c_LVL_FULL   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [c_HOLD_W-1:0]   c_HOLD_INIT  = c_HOLD_W'(SEND_HOLD);
    localparam logic [c_HOLD_W-1:0]   c_HOLD_ONE   = c_HOLD_W'(1);
    localparam logic [c_TO_W-1:0]     c_TO_ONE     = c_TO_W'(1);
    localparam logic [c_TO_W-1:0]     c_TO_LAST    = c_TO_W'(START_TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE       = 2'd0;
    localparam logic [1:0] c_ST_PULSE      = 2'd1;
    localparam logic [1:0] c_ST_WAIT_START = 2'd2;
    localparam logic [1:0] c_ST_WAIT_DONE  = 2'd3;

    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [7:0]            r_d_in;
    logic                  r_overflow;
    logic                  r_timeout_err;
    logic                  r_snd_meta;
    logic                  r_snd_s;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_HOLD_W-1:0]   r_hold;
    logic [c_HOLD_W-1:0]   w_hold_nxt;
    logic [c_TO_W-1:0]     r_to_cnt;
    logic [c_TO_W-1:0]     w_to_cnt_nxt;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_overflow;
    logic w_timeout;

    assign w_full  = (r_level == c_LVL_FULL);
    assign w_empty = (r_level == '0);

    // A pop in the same cycle frees a slot, so a write while full still lands.
    assign w_push     = wr_en && (!w_full || w_pop);
    assign w_overflow = wr_en && w_full && !w_pop;

    // sending lives in the UART clock domain
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_snd_meta <= 1'b0;
            r_snd_s    <= 1'b0;
        end else begin
            r_snd_meta <= sending;
            r_snd_s    <= r_snd_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_d_in     <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                r_d_in   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
            r_overflow <= w_overflow;
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_state       <= c_ST_IDLE;
            r_hold        <= '0;
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hold        <= w_hold_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_timeout_err <= w_timeout;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold;
        w_to_cnt_nxt = r_to_cnt;
        w_pop        = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_hold_nxt  = c_HOLD_INIT;
                    w_state_nxt = c_ST_PULSE;
                end
            end
            c_ST_PULSE: begin
                w_hold_nxt = r_hold - c_HOLD_ONE;
                if (r_hold == c_HOLD_ONE) begin
                    w_to_cnt_nxt = '0;
                    w_state_nxt  = c_ST_WAIT_START;
                end
            end
            c_ST_WAIT_START: begin
                // A frame already in progress on entry counts as the start.
                if (r_snd_s) begin
                    w_state_nxt = c_ST_WAIT_DONE;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + c_TO_ONE;
                end
            end
            c_ST_WAIT_DONE: begin
                if (!r_snd_s) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

`ifdef UART_TXQ_DROP_COUNT_EN
    logic [7:0] r_drop_count;
    logic [1:0] w_drop_inc;
    logic [8:0] w_drop_sum;

    assign w_drop_inc = {1'b0, r_overflow} + {1'b0, r_timeout_err};
    assign w_drop_sum = {1'b0, r_drop_count} + {7'd0, w_drop_inc};

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_drop_count <= 8'h00;
        end else if (w_drop_sum[8]) begin
            r_drop_count <= 8'hFF;
        end else begin
            r_drop_count <= w_drop_sum[7:0];
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign full        = w_full;
    assign empty       = w_empty;
    assign level       = r_level;
    assign d_in        = r_d_in;
    assign tx_send     = (r_state == c_ST_PULSE);
    assign busy        = (r_state != c_ST_IDLE);
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
